// File: rtl/spi_apb_master.sv
// spi_apb_master: APB4 initiator that turns a single-outstanding
// command/response interface into APB transfers towards the SPI APB
// slave register file. One transfer at a time: IDLE -> SETUP -> ACCESS.
// Optional ACCESS wait-state timeout is enabled by defining the macro
// SPI_APB_MASTER_TIMEOUT_EN (default build: no timeout, rsp_timeout tied 0).
module spi_apb_master #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    state_e              state_q;
    state_e              state_d;
    logic                cmdReady_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic                rspValid_q;
    logic [DATA_W-1:0]   rspRdata_q;
    logic                rspErr_q;
    logic                accept;
    logic                complete;
    logic                timeoutHit;

`ifdef SPI_APB_MASTER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0]   waitCnt_q;
    logic                rspTimeout_q;

    // Count ACCESS cycles spent waiting for pready; restart every SETUP
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            waitCnt_q <= '0;
        end else if (state_q == SETUP) begin
            waitCnt_q <= '0;
        end else if ((state_q == ACCESS) && !pready) begin
            waitCnt_q <= waitCnt_q + 1'b1;
        end
    end

    // Abort on the last allowed wait cycle; a same-cycle pready wins
    assign timeoutHit = (state_q == ACCESS) && !pready &&
                        (waitCnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    // Timeout flag of the most recent response
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            rspTimeout_q <= 1'b0;
        end else if (complete) begin
            rspTimeout_q <= 1'b0;
        end else if (timeoutHit) begin
            rspTimeout_q <= 1'b1;
        end
    end

    assign rsp_timeout = rspTimeout_q;
`else
    assign timeoutHit  = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // State register; async reset aborts any transfer in flight
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: SETUP is always a single cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready || timeoutHit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: APB control straight from state, handshake strobes
    always_comb begin
        psel     = 1'b0;
        penable  = 1'b0;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                accept = cmd_valid && cmdReady_q;
            end
            SETUP: begin
                psel = 1'b1;
            end
            ACCESS: begin
                psel     = 1'b1;
                penable  = 1'b1;
                complete = pready;
            end
            default: begin
                psel = 1'b0;
            end
        endcase
    end

    // cmd_ready is registered so it stays low during reset and rises the cycle after
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cmdReady_q <= 1'b0;
        end else begin
            cmdReady_q <= (state_d == IDLE);
        end
    end

    // Capture the command on accept; held through ACCESS and after completion
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end else if (accept) begin
            pwrite_q <= cmd_write;
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
            pstrb_q  <= cmd_write ? cmd_strb : '0;
        end
    end

    // One-cycle response pulse; data and error hold until the next response
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
        end else begin
            rspValid_q <= complete || timeoutHit;
            if (complete) begin
                rspRdata_q <= pwrite_q ? '0 : prdata;
                rspErr_q   <= pslverr;
            end else if (timeoutHit) begin
                rspRdata_q <= '0;
                rspErr_q   <= 1'b1;
            end
        end
    end

    assign cmd_ready = cmdReady_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;

endmodule

// File: tb/tb_spi_apb_master.sv
// tb_spi_apb_master: directed stimulus with a response scoreboard.
// Commands push their expected response into a queue; a monitor pops and
// compares on every rsp_valid. A small APB slave model supplies pready,
// prdata and pslverr with configurable wait states.
module tb_spi_apb_master;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } rsp_t;

    logic                pclk;
    logic                preset_n;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_write;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic [DATA_W/8-1:0] cmd_strb;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic                rsp_timeout;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [ADDR_W-1:0]   paddr;
    logic [DATA_W-1:0]   pwdata;
    logic [DATA_W/8-1:0] pstrb;
    logic [DATA_W-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    int   checks = 0;
    int   errors = 0;
    rsp_t expQ[$];

    int          cfgWait     = 0;
    logic [31:0] cfgRdata    = 32'h0;
    logic        cfgErr      = 1'b0;
    logic        cfgErrEarly = 1'b0;
    logic        cfgStuck    = 1'b0;

    spi_apb_master #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .pclk(pclk),
        .preset_n(preset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .pstrb(pstrb),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Hard stop in case something wedges beyond every local bound
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got still running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one command, wait for the accept edge, and queue its response
    task automatic applyStimulus(input logic w, input logic [4:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input rsp_t exp, input bit expectRsp);
        int waited;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge pclk);
            waited++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL cmd_accept: got cmd_ready=0 expected 1 within 50 cycles");
            cmd_valid = 1'b0;
        end else begin
            if (expectRsp) expQ.push_back(exp);
            @(posedge pclk);
            #1 cmd_valid = 1'b0;
        end
    endtask

    // Advance to the negedge where rsp_valid is seen, bounded
    task automatic waitRsp();
        int k;
        k = 0;
        do begin
            @(negedge pclk);
            k++;
        end while (!rsp_valid && k < 100);
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL rsp_wait: got no rsp_valid expected one within 100 cycles");
        end
    endtask

    // APB slave model evaluated on the falling edge
    initial begin : slaveModel
        int slvWait;
        slvWait = 0;
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        forever begin
            @(negedge pclk);
            if (psel && penable) begin
                if (cfgStuck || slvWait < cfgWait) begin
                    pready  = 1'b0;
                    pslverr = cfgErrEarly;
                    prdata  = 32'hBAD0_0BAD;
                    slvWait++;
                end else begin
                    pready  = 1'b1;
                    pslverr = cfgErr;
                    prdata  = cfgRdata;
                end
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
                prdata  = '0;
                slvWait = 0;
            end
        end
    end

    // Scoreboard monitor: every response must match the oldest expectation
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge pclk);
            if (preset_n && rsp_valid) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_rsp: got rdata=0x%08h err=%0b tmo=%0b expected no response",
                             rsp_rdata, rsp_err, rsp_timeout);
                end else begin
                    e = expQ.pop_front();
                    if ({rsp_rdata, rsp_err, rsp_timeout} !== e) begin
                        errors++;
                        $display("[TB] FAIL rsp_compare: got rdata=0x%08h err=%0b tmo=%0b expected rdata=0x%08h err=%0b tmo=%0b",
                                 rsp_rdata, rsp_err, rsp_timeout, e.rdata, e.err, e.tmo);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int badCycles;
        int n;
        preset_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;

        // Reset state
        repeat (2) @(negedge pclk);
        checkOutput("reset_cmd_ready", cmd_ready, 0);
        checkOutput("reset_psel", psel, 0);
        checkOutput("reset_penable", penable, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_paddr", paddr, 0);
        checkOutput("reset_pwdata", pwdata, 0);
        preset_n = 1'b1;
        @(negedge pclk);
        checkOutput("post_reset_cmd_ready", cmd_ready, 1);

        // Write CR, zero wait states, slave drives junk prdata that must not leak
        $display("[TB] write CR");
        cfgWait = 0; cfgErr = 0; cfgRdata = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 5'h00, 32'h0000_0018, 4'hF, '{32'h0, 1'b0, 1'b0}, 1'b1);
        @(negedge pclk);
        checkOutput("wr_setup_psel", psel, 1);
        checkOutput("wr_setup_penable", penable, 0);
        checkOutput("wr_setup_cmd_ready", cmd_ready, 0);
        @(negedge pclk);
        checkOutput("wr_access_penable", penable, 1);
        checkOutput("wr_access_paddr", paddr, 32'h00);
        checkOutput("wr_access_pwdata", pwdata, 32'h18);
        checkOutput("wr_access_pwrite", pwrite, 1);
        checkOutput("wr_access_pstrb", pstrb, 32'hF);
        @(negedge pclk);
        checkOutput("wr_rsp_latency", rsp_valid, 1);
        checkOutput("wr_rsp_cmd_ready", cmd_ready, 1);
        checkOutput("wr_rsp_psel", psel, 0);
        @(negedge pclk);
        checkOutput("wr_rsp_one_cycle", rsp_valid, 0);

        // Read BR: strobes forced to zero
        $display("[TB] read BR");
        cfgRdata = 32'h0000_0014;
        applyStimulus(1'b0, 5'h04, 32'h1234_5678, 4'hF, '{32'h14, 1'b0, 1'b0}, 1'b1);
        repeat (2) @(negedge pclk);
        checkOutput("rd_access_pstrb", pstrb, 0);
        checkOutput("rd_access_pwrite", pwrite, 0);
        checkOutput("rd_access_paddr", paddr, 32'h04);
        waitRsp();

        // Slave error on INTER write, then a normal SR read
        $display("[TB] slave error");
        cfgErr = 1;
        applyStimulus(1'b1, 5'h08, 32'h0000_0003, 4'hB, '{32'h0, 1'b1, 1'b0}, 1'b1);
        repeat (2) @(negedge pclk);
        checkOutput("err_access_pstrb", pstrb, 32'hB);
        waitRsp();
        cfgErr = 0; cfgRdata = 32'h0000_0003;
        applyStimulus(1'b0, 5'h0C, 32'h0, 4'h0, '{32'h3, 1'b0, 1'b0}, 1'b1);
        waitRsp();
        @(negedge pclk);
        checkOutput("idle_paddr_hold", paddr, 32'h0C);
        checkOutput("idle_psel", psel, 0);

        // Three wait states with early pslverr ignored, then back-to-back read
        $display("[TB] wait states and back-to-back");
        cfgWait = 3; cfgErrEarly = 1; cfgRdata = 32'h0000_00C3;
        applyStimulus(1'b1, 5'h18, 32'hA5A5_5A5A, 4'hF, '{32'h0, 1'b0, 1'b0}, 1'b1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h1C; cmd_wdata = 32'h0; cmd_strb = 4'h0;
        expQ.push_back('{32'hC3, 1'b0, 1'b0});
        @(negedge pclk);
        badCycles = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            if (!(psel && penable) || paddr !== 5'h18 || pwdata !== 32'hA5A5_5A5A || rsp_valid)
                badCycles++;
        end
        checkOutput("wait_access_stable", badCycles, 0);
        @(negedge pclk);
        checkOutput("b2b_rsp_valid", rsp_valid, 1);
        checkOutput("b2b_gap_psel", psel, 0);
        checkOutput("b2b_gap_cmd_ready", cmd_ready, 1);
        cfgWait = 0; cfgErrEarly = 0;
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        @(negedge pclk);
        checkOutput("b2b_second_psel", psel, 1);
        checkOutput("b2b_second_paddr", paddr, 32'h1C);
        waitRsp();

`ifdef SPI_APB_MASTER_TIMEOUT_EN
        // Timeout after 16 ACCESS cycles
        $display("[TB] timeout");
        cfgStuck = 1;
        applyStimulus(1'b0, 5'h10, 32'h0, 4'h0, '{32'h0, 1'b1, 1'b1}, 1'b1);
        @(negedge pclk);
        n = 0;
        @(negedge pclk);
        while (psel && penable && n < 100) begin
            n++;
            @(negedge pclk);
        end
        checkOutput("timeout_access_cycles", n, 16);
        checkOutput("timeout_rsp_valid", rsp_valid, 1);
        // pready on the limit cycle completes normally
        cfgStuck = 0; cfgWait = 15; cfgRdata = 32'h0000_0055;
        applyStimulus(1'b0, 5'h14, 32'h0, 4'h0, '{32'h55, 1'b0, 1'b0}, 1'b1);
        waitRsp();
        cfgWait = 0;
        cfgStuck = 1;
        applyStimulus(1'b0, 5'h10, 32'h0, 4'h0, '{32'h0, 1'b0, 1'b0}, 1'b0);
        repeat (4) @(negedge pclk);
`else
        // Without the timeout the transfer waits forever
        $display("[TB] stuck pready");
        cfgStuck = 1;
        applyStimulus(1'b0, 5'h10, 32'h0, 4'h0, '{32'h0, 1'b0, 1'b0}, 1'b0);
        @(negedge pclk);
        badCycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge pclk);
            if (!(psel && penable) || rsp_valid) badCycles++;
        end
        checkOutput("stuck_no_rsp", badCycles, 0);
        checkOutput("stuck_rsp_timeout", rsp_timeout, 0);
`endif

        // Reset in the middle of ACCESS
        $display("[TB] reset mid-access");
        checkOutput("pre_reset_penable", penable, 1);
        @(posedge pclk);
        #2 preset_n = 1'b0;
        #1;
        checkOutput("async_reset_psel", psel, 0);
        checkOutput("async_reset_penable", penable, 0);
        checkOutput("async_reset_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge pclk);
        cfgStuck = 0; cfgRdata = 32'h0000_0081;
        preset_n = 1'b1;
        @(negedge pclk);
        checkOutput("rerelease_cmd_ready", cmd_ready, 1);
        applyStimulus(1'b0, 5'h0C, 32'h0, 4'h0, '{32'h81, 1'b0, 1'b0}, 1'b1);
        waitRsp();
        repeat (3) @(negedge pclk);

        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
